cond_unit: RTL and testbench
============================

// Module: cond_unit
// PURPOSE
//   Condition-check stage directly downstream of the ALU. Holds the architectural
//   NZCV flag register, loaded from ALUFlags. Evaluates the instruction's 4-bit
//   condition field against the stored flags, and gates the decoder's PCS, RegW and
//   MemW requests into the committed PCSrc, RegWrite and MemWrite strobes.
//   Stall freezes all state.
// PARAMETERS
//   CNT_W   32   width of the execute/skip statistics counters (COND_STATS_EN only)
// PORTS
//   CLK        in   1      single clock; all state updates on rising edge
//   RESETn     in   1      asynchronous, active-low reset
//   Cond       in   4      instruction condition field, Instr[31:28]
//   ALUFlags   in   4      {N,Z,C,V} from the ALU for the current instruction
//   FlagW      in   2      [1]: request NZ update; [0]: request CV update
//   PCS        in   1      decoder: instruction writes PC
//   RegW       in   1      decoder: instruction writes register file
//   MemW       in   1      decoder: instruction writes memory
//   NoWrite    in   1      decoder: compare-class instruction (CMP/CMN); suppress RegWrite
//   Stall      in   1      pipeline hold; current instruction is not committed
//   PCSrc      out  1      committed PC write
//   RegWrite   out  1      committed register write
//   MemWrite   out  1      committed memory write
//   CondEx     out  1      condition passed against the stored flags
//   Flags      out  4      current stored {N,Z,C,V}
//   ExecCount  out  CNT_W  instructions committed with CondEx=1 (COND_STATS_EN only)
//   SkipCount  out  CNT_W  instructions committed with CondEx=0 (COND_STATS_EN only)
// BEHAVIOUR
//   - Reset (RESETn=0, async): Flags=4'b0000; counters=0. Outputs follow combinationally
//     from the reset flags: PCSrc/RegWrite/MemWrite are 0 unless Cond passes on NZCV=0000.
//   - CondEx is combinational from Cond and the stored Flags, never from ALUFlags
//     (0-cycle latency):
//       0000 EQ Z          | 0001 NE !Z           | 0010 CS C          | 0011 CC !C
//       0100 MI N          | 0101 PL !N           | 0110 VS V          | 0111 VC !V
//       1000 HI C&!Z       | 1001 LS !C|Z         | 1010 GE N==V       | 1011 LT N!=V
//       1100 GT !Z&(N==V)  | 1101 LE Z|(N!=V)     | 1110 AL 1          | 1111 NV 0 (reserved)
//   - Commit = CondEx & !Stall.
//     PCSrc    = PCS  & Commit
//     RegWrite = RegW & Commit & !NoWrite
//     MemWrite = MemW & Commit
//   - Flag register, per rising CLK edge:
//     if Commit & FlagW[1]: {N,Z} <= ALUFlags[3:2]
//     if Commit & FlagW[0]: {C,V} <= ALUFlags[1:0]
//     Groups update independently; otherwise they hold. The new flags are visible on
//     Flags and CondEx from the next cycle (1-cycle latency).
//   - Stall=1: no flag update, no counter update, all three strobes 0. CondEx still
//     reflects the stored flags.
//   - A failed condition never updates flags, even with FlagW!=0.
//   - Reset asserted mid-cycle clears Flags immediately; an in-flight update is lost.
//   - Logical-op ALUFlags with C=V=0 are written as given; the decoder sets FlagW=2'b10
//     for logical S-instructions so C,V are kept.
// CONFIGURATION
//   COND_STATS_EN defined:
//     - ExecCount increments on each cycle with Commit=1.
//     - SkipCount increments on each cycle with CondEx=0 & !Stall.
//     - Both saturate at {CNT_W{1'b1}} (no wrap) and clear on reset.
//   COND_STATS_EN undefined:
//     - ExecCount and SkipCount are tied to 0 and no counter flops are inferred.
//     - The port list is unchanged.
// TESTING
//   1 Reset: RESETn=0 -> Flags=0000. Cond=0000(EQ),RegW=1 -> CondEx=0, RegWrite=0.
//     Cond=1110(AL),RegW=1 -> RegWrite=1.
//   2 Flag load: Cond=AL, FlagW=11, ALUFlags=0110, one edge -> Flags=0110.
//     Next cycle Cond=EQ -> CondEx=1; Cond=HI -> CondEx=0.
//   3 Partial write: Flags=1111, FlagW=10, ALUFlags=0000 -> Flags=0011.
//     Then FlagW=01, ALUFlags=0001 -> Flags=0001.
//   4 Failed cond: Flags=0000, Cond=EQ, FlagW=11, ALUFlags=0100, PCS=1, MemW=1
//     -> PCSrc=0, MemWrite=0, Flags stay 0000.
//   5 Stall and NoWrite: Cond=AL, RegW=1, FlagW=11, ALUFlags=1000, Stall=1
//     -> RegWrite=0, Flags unchanged. Stall=0, NoWrite=1 -> RegWrite=0, Flags=1000.
//   6 Signed conds, all 16 codes over NZCV sweep; e.g. Flags=1001: GE=1, LT=0, GT=1, LE=0.
//     With COND_STATS_EN and CNT_W=2: 5 commits -> ExecCount=3 (saturated).

Source files
------------

// File: rtl/cond_unit.sv
// -----------------------------------------------------------------------------
// cond_unit -- condition-check stage sitting directly after the ALU.
//
// Holds the architectural NZCV flag register. The instruction's condition field
// is evaluated against the *stored* flags (never the incoming ALUFlags). The
// decoder's PCS/RegW/MemW requests are gated into the committed strobes.
// Stall freezes all state and suppresses every strobe.
//
// Optional feature (compile-time macro): COND_STATS_EN
//   defined   -> ExecCount / SkipCount saturating statistics counters
//   undefined -> ExecCount / SkipCount tied to zero, no counter flops
//
// Parameters
//   CNT_W      width of the statistics counters
//
// Ports
//   CLK        in   1      clock, rising edge
//   RESETn     in   1      asynchronous active-low reset
//   Cond       in   4      instruction condition field (Instr[31:28])
//   ALUFlags   in   4      {N,Z,C,V} produced by the ALU
//   FlagW      in   2      [1] update NZ, [0] update CV
//   PCS        in   1      decoder: instruction writes PC
//   RegW       in   1      decoder: instruction writes register file
//   MemW       in   1      decoder: instruction writes memory
//   NoWrite    in   1      decoder: compare-class op, suppress RegWrite
//   Stall      in   1      pipeline hold, current instruction not committed
//   PCSrc      out  1      committed PC write
//   RegWrite   out  1      committed register write
//   MemWrite   out  1      committed memory write
//   CondEx     out  1      condition passes against the stored flags
//   Flags      out  4      stored {N,Z,C,V}
//   ExecCount  out  CNT_W  committed instructions with CondEx=1
//   SkipCount  out  CNT_W  non-stalled instructions with CondEx=0
// -----------------------------------------------------------------------------
module cond_unit #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             Stall,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SkipCount
);

  logic [3:0] flags_reg;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       cond_ex;
  logic       commit;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_reg;

  // Condition decode from the stored flags only.
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = !flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = !flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = !flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = !flag_v;
      4'b1000: cond_ex = flag_c && !flag_z;
      4'b1001: cond_ex = !flag_c || flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = !flag_z && (flag_n == flag_v);
      4'b1101: cond_ex = flag_z || (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;   // NV: reserved, never executes
    endcase
  end

  assign commit   = cond_ex && !Stall;
  assign CondEx   = cond_ex;
  assign PCSrc    = PCS  && commit;
  assign RegWrite = RegW && commit && !NoWrite;
  assign MemWrite = MemW && commit;
  assign Flags    = flags_reg;

  // Two independent flag groups: gi=1 -> {N,Z} (bits 3:2), gi=0 -> {C,V}
  // (bits 1:0). Each group loads only when the instruction commits and its
  // FlagW bit is set, so logical ops with FlagW=10 keep C and V.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_flag_grp
      logic [1:0] grp_reg;
      logic [1:0] grp_next;

      always_comb begin
        grp_next = grp_reg;
        if (commit && FlagW[gi]) begin
          grp_next = ALUFlags[2*gi +: 2];
        end
      end

      always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
          grp_reg <= 2'b00;
        end else begin
          grp_reg <= grp_next;
        end
      end

      assign flags_reg[2*gi +: 2] = grp_reg;
    end
  endgenerate

`ifdef COND_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] exec_reg, exec_next;
  logic [CNT_W-1:0] skip_reg, skip_next;

  // Saturating counters: once at all-ones they stick until reset.
  always_comb begin
    exec_next = exec_reg;
    skip_next = skip_reg;
    if (commit && (exec_reg != CNT_MAX)) begin
      exec_next = exec_reg + CNT_W'(1);
    end
    if (!cond_ex && !Stall && (skip_reg != CNT_MAX)) begin
      skip_next = skip_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      exec_reg <= '0;
      skip_reg <= '0;
    end else begin
      exec_reg <= exec_next;
      skip_reg <= skip_next;
    end
  end

  assign ExecCount = exec_reg;
  assign SkipCount = skip_reg;
`else
  assign ExecCount = '0;
  assign SkipCount = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// -----------------------------------------------------------------------------
// tb_cond_unit -- self-checking bench for cond_unit.
// Directed sequences for reset, flag loading, partial writes, failed conditions,
// stall/NoWrite and async reset; a table of {flags, cond, expected CondEx}
// records; then randomized traffic checked against a behavioural model.
// Statistics checks follow COND_STATS_EN (zero when the macro is undefined).
// -----------------------------------------------------------------------------
module tb_cond_unit;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK;
  logic             RESETn;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS, RegW, MemW, NoWrite, Stall;
  logic             PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] ExecCount, SkipCount;

  cond_unit #(.CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .Cond      (Cond),
    .ALUFlags  (ALUFlags),
    .FlagW     (FlagW),
    .PCS       (PCS),
    .RegW      (RegW),
    .MemW      (MemW),
    .NoWrite   (NoWrite),
    .Stall     (Stall),
    .PCSrc     (PCSrc),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .CondEx    (CondEx),
    .Flags     (Flags),
    .ExecCount (ExecCount),
    .SkipCount (SkipCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  logic [3:0] m_flags;
  int         m_exec;
  int         m_skip;

  localparam logic [3:0] C_EQ = 4'b0000, C_NE = 4'b0001, C_CS = 4'b0010, C_CC = 4'b0011;
  localparam logic [3:0] C_MI = 4'b0100, C_PL = 4'b0101, C_VS = 4'b0110, C_VC = 4'b0111;
  localparam logic [3:0] C_HI = 4'b1000, C_LS = 4'b1001, C_GE = 4'b1010, C_LT = 4'b1011;
  localparam logic [3:0] C_GT = 4'b1100, C_LE = 4'b1101, C_AL = 4'b1110, C_NV = 4'b1111;

  // Conditions come in complementary pairs: odd codes invert the even base.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return cond[0] ? ~base : base;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] cond, input logic [3:0] aluf, input logic [1:0] fw,
                        input logic pcs, input logic regw, input logic memw,
                        input logic nowr, input logic stall);
    Cond = cond; ALUFlags = aluf; FlagW = fw;
    PCS = pcs; RegW = regw; MemW = memw; NoWrite = nowr; Stall = stall;
  endtask

  // Compare all outputs against the model, then clock and advance the model.
  task automatic tick(input string tag);
    logic ce, cm;
    ce = cond_pass(Cond, m_flags);
    cm = ce & ~Stall;
    check({tag, "_condex"},   CondEx,   ce);
    check({tag, "_pcsrc"},    PCSrc,    PCS & cm);
    check({tag, "_regwrite"}, RegWrite, RegW & cm & ~NoWrite);
    check({tag, "_memwrite"}, MemWrite, MemW & cm);
    check({tag, "_flags"},    Flags,    m_flags);
`ifdef COND_STATS_EN
    check({tag, "_exec"}, ExecCount, m_exec);
    check({tag, "_skip"}, SkipCount, m_skip);
`else
    check({tag, "_exec"}, ExecCount, 0);
    check({tag, "_skip"}, SkipCount, 0);
`endif
    @(posedge CLK);
    #1;
    if (!RESETn) begin
      m_flags = 4'b0000; m_exec = 0; m_skip = 0;
    end else begin
      if (cm && FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
      if (cm && FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
      if (cm && m_exec < CNT_MAX) m_exec++;
      if (!ce && !Stall && m_skip < CNT_MAX) m_skip++;
    end
  endtask

  task automatic load_flags(input logic [3:0] f);
    set_in(C_AL, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    tick("load");
  endtask

  typedef struct {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       exp;
  } vec_t;

  vec_t vecs[24];

  initial begin
    vecs[0]  = '{4'b0110, C_EQ, 1'b1};
    vecs[1]  = '{4'b0110, C_HI, 1'b0};
    vecs[2]  = '{4'b0110, C_LS, 1'b1};
    vecs[3]  = '{4'b0110, C_GE, 1'b1};
    vecs[4]  = '{4'b1001, C_GE, 1'b1};
    vecs[5]  = '{4'b1001, C_LT, 1'b0};
    vecs[6]  = '{4'b1001, C_GT, 1'b1};
    vecs[7]  = '{4'b1001, C_LE, 1'b0};
    vecs[8]  = '{4'b1001, C_VS, 1'b1};
    vecs[9]  = '{4'b1001, C_CC, 1'b1};
    vecs[10] = '{4'b0000, C_EQ, 1'b0};
    vecs[11] = '{4'b0000, C_NE, 1'b1};
    vecs[12] = '{4'b0000, C_AL, 1'b1};
    vecs[13] = '{4'b0000, C_NV, 1'b0};
    vecs[14] = '{4'b0000, C_LS, 1'b1};
    vecs[15] = '{4'b0010, C_HI, 1'b1};
    vecs[16] = '{4'b0010, C_CS, 1'b1};
    vecs[17] = '{4'b0010, C_PL, 1'b1};
    vecs[18] = '{4'b1000, C_MI, 1'b1};
    vecs[19] = '{4'b1000, C_LT, 1'b1};
    vecs[20] = '{4'b1000, C_GE, 1'b0};
    vecs[21] = '{4'b1000, C_LE, 1'b1};
    vecs[22] = '{4'b0100, C_GT, 1'b0};
    vecs[23] = '{4'b0001, C_VC, 1'b0};

    m_flags = 4'b0000; m_exec = 0; m_skip = 0;
    RESETn = 1'b0;
    set_in(C_EQ, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;

    // Reset state: EQ fails on NZCV=0000, AL passes.
    #3;
    check("t1_flags", Flags, 4'b0000);
    check("t1_eq_condex", CondEx, 1'b0);
    check("t1_eq_regwrite", RegWrite, 1'b0);
    tick("t1a");
    set_in(C_AL, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #3;
    check("t1_al_regwrite", RegWrite, 1'b1);
    tick("t1b");
    RESETn = 1'b1;
    $display("[TB] seq reset done");

    // Flag load with one-cycle latency.
    set_in(C_AL, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    check("t2_flags_before", Flags, 4'b0000);
    tick("t2a");
    check("t2_flags_after", Flags, 4'b0110);
    set_in(C_EQ, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    check("t2_eq", CondEx, 1'b1);
    tick("t2b");
    set_in(C_HI, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    check("t2_hi", CondEx, 1'b0);
    tick("t2c");
    $display("[TB] seq flag load done");

    // Partial writes: NZ only, then CV only.
    load_flags(4'b1111);
    set_in(C_AL, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    tick("t3a");
    check("t3_nz_only", Flags, 4'b0011);
    set_in(C_AL, 4'b0001, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    tick("t3b");
    check("t3_cv_only", Flags, 4'b0001);
    $display("[TB] seq partial write done");

    // Failed condition: no strobes, no flag update.
    load_flags(4'b0000);
    set_in(C_EQ, 4'b0100, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #3;
    check("t4_pcsrc", PCSrc, 1'b0);
    check("t4_memwrite", MemWrite, 1'b0);
    tick("t4");
    check("t4_flags", Flags, 4'b0000);
    $display("[TB] seq failed cond done");

    // Stall holds everything; NoWrite blocks only RegWrite.
    set_in(C_AL, 4'b1000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    #3;
    check("t5_stall_regwrite", RegWrite, 1'b0);
    check("t5_stall_condex", CondEx, 1'b1);
    tick("t5a");
    check("t5_stall_flags", Flags, 4'b0000);
    set_in(C_AL, 4'b1000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #3;
    check("t5_nowrite_regwrite", RegWrite, 1'b0);
    tick("t5b");
    check("t5_nowrite_flags", Flags, 4'b1000);
    $display("[TB] seq stall/nowrite done");

    // Condition table.
    for (int i = 0; i < 24; i++) begin
      load_flags(vecs[i].flags);
      set_in(vecs[i].cond, 4'($urandom), 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      #3;
      check($sformatf("vec%0d_condex", i), CondEx, vecs[i].exp);
      check($sformatf("vec%0d_pcsrc", i), PCSrc, vecs[i].exp);
      $display("[TB] vec %0d flags=%b cond=%b condex=%b", i, vecs[i].flags, vecs[i].cond, CondEx);
      tick($sformatf("vec%0d", i));
    end

    // Async reset mid-cycle drops an in-flight update.
    load_flags(4'b1111);
    set_in(C_AL, 4'b0101, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    RESETn = 1'b0;
    #1;
    check("t6_async_flags", Flags, 4'b0000);
    check("t6_async_exec", ExecCount, 0);
    m_flags = 4'b0000; m_exec = 0; m_skip = 0;
    @(posedge CLK);
    #1;
    check("t6_held_flags", Flags, 4'b0000);
    RESETn = 1'b1;
    $display("[TB] seq async reset done");

    // Five commits from reset; counter saturates at 3 with CNT_W=2.
    for (int i = 0; i < 5; i++) begin
      set_in(C_AL, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      #3;
      tick("t6_sat");
    end
`ifdef COND_STATS_EN
    check("t6_exec_sat", ExecCount, 3);
`else
    check("t6_exec_tied", ExecCount, 0);
`endif
    $display("[TB] seq saturation done");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      set_in(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      #3;
      tick("rand");
    end
    $display("[TB] random phase done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
